branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Branch target buffer plus 2-bit saturating direction predictor that drives the program counter's take_branch / branch_predict inputs.
- Lookup is a combinational read of registered state, indexed by the current fetch PC, and is valid in the same cycle.
- Execute stage sends resolved branches back through an update port; the table is trained on the following clock edge.
- Keeps performance counters for resolved branches and mispredictions.

Parameters:
ADDR_WIDTH, 16, instruction address width; addresses are halfword-aligned, bit 0 always 0.
INDEX_BITS, 4, log2 of table entries (16 entries).
COUNT_WIDTH, 16, width of the performance counters.

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
lookup_pc  input  ADDR_WIDTH  current fetch PC
take_branch  output  1  predict taken for lookup_pc
branch_predict  output  ADDR_WIDTH  predicted target for lookup_pc
update_valid  input  1  a branch resolved this cycle
update_pc  input  ADDR_WIDTH  PC of the resolved branch
update_taken  input  1  actual direction
update_target  input  ADDR_WIDTH  actual target (meaningful when taken)
update_pred_taken  input  1  direction that was predicted for this branch
update_pred_target  input  ADDR_WIDTH  target that was predicted
invalidate  input  1  clear all entries (context change)
branch_count  output  COUNT_WIDTH  resolved branches since reset
mispredict_count  output  COUNT_WIDTH  mispredictions since reset

Behaviour:
- Address split:
  - index = pc[INDEX_BITS:1]
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+1]
  - Per entry: valid, tag, target[ADDR_WIDTH], ctr[1:0].
- Lookup (combinational from registers):
  - hit = valid[idx] & tag match.
  - take_branch = hit & ctr[1].
  - branch_predict = target[idx] when hit, else 0.
- Update on posedge when update_valid and no reset/invalidate:
  - Hit, taken: ctr saturating +1 (max 3); target <= update_target.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate (replace): valid=1, tag, target=update_target, ctr=2 (weakly taken).
  - Miss, not taken: no table change.
- Mispredict = update_pred_taken != update_taken, or both taken and update_pred_target != update_target.
- Counters, per cycle with update_valid:
  - branch_count increments by 1.
  - mispredict_count increments by 1 if mispredict.
  - Both saturate at all-ones; no wrap.
- Latency: an update becomes visible to lookup the cycle after the update edge. No bypass; a same-cycle lookup to the same index sees the old entry.
- invalidate: clears every valid bit on the next edge and suppresses any same-cycle update. Ctr/target/tag contents are don't-care; counters are unaffected.
- Reset (synchronous, highest priority, overrides update and invalidate):
  - All valid = 0, all ctr = 1, branch_count = mispredict_count = 0.
  - Outputs after reset: take_branch = 0, branch_predict = 0.
- No stall input. The table trains whenever update_valid is high; upstream must not assert update_valid twice for one branch.
- Aliasing: tag mismatch on an occupied index is a miss. Taken updates overwrite the entry unconditionally.

Test Plan:
- Reset, then lookup_pc=0x0040 -> take_branch=0, branch_predict=0x0000, both counters 0.
- Update pc=0x0040 taken target=0x0100, pred_taken=0 -> next cycle lookup 0x0040 gives take_branch=1, branch_predict=0x0100; branch_count=1, mispredict_count=1.
- Two not-taken updates to 0x0040 after allocate (ctr 2→1→0) -> take_branch=0 after the first. A subsequent taken update (ctr=1) keeps take_branch=0; a second taken update (ctr=2) gives take_branch=1.
- Alias test: allocate 0x0040 taken, then lookup 0x0060 (same index 0, different tag) -> take_branch=0. Taken update at 0x0060 target 0x0200 -> lookup 0x0040 misses, lookup 0x0060 hits with 0x0200.
- Same-cycle update and lookup of 0x0040 -> lookup shows pre-update value that cycle, new value next cycle. invalidate asserted with update_valid -> all lookups miss, counters still increment.
- Assert reset while update_valid=1 with a valid table -> table cleared, counters 0, and no entry allocated from that update.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is a combinational read of the table; training happens on the edge after a resolved branch.
module branch_predictor #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_BITS  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  lookup_pc,
  output logic                   take_branch,
  output logic [ADDR_WIDTH-1:0]  branch_predict,
  input  logic                   update_valid,
  input  logic [ADDR_WIDTH-1:0]  update_pc,
  input  logic                   update_taken,
  input  logic [ADDR_WIDTH-1:0]  update_target,
  input  logic                   update_pred_taken,
  input  logic [ADDR_WIDTH-1:0]  update_pred_target,
  input  logic                   invalidate,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 1;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] count_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Bit 0 of every PC is always zero (halfword-aligned) and carries no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;

  assign lk_idx = lookup_pc[INDEX_BITS:1];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign take_branch    = lk_hit & ctr_q[lk_idx][1];
  assign branch_predict = lk_hit ? target_q[lk_idx] : '0;

  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  mispredict;
  logic                  up_write_data;

  assign up_idx = update_pc[INDEX_BITS:1];
  assign up_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // A target mismatch only counts when both the prediction and the outcome were taken.
  assign mispredict = (update_pred_taken != update_taken) ||
                      (update_taken && update_pred_taken && (update_pred_target != update_target));

  // Taken updates either refresh a hit's target or allocate over whatever occupies the index.
  assign up_write_data = update_valid && update_taken && !invalidate && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd1;
    end else begin
      if (update_valid) begin
        branch_count <= count_inc(branch_count);
        if (mispredict) mispredict_count <= count_inc(mispredict_count);
      end
      if (invalidate) begin
        valid_q <= '0;
      end else if (update_valid) begin
        if (up_hit) begin
          ctr_q[up_idx] <= update_taken ? ctr_inc(ctr_q[up_idx]) : ctr_dec(ctr_q[up_idx]);
        end else if (update_taken) begin
          valid_q[up_idx] <= 1'b1;
          ctr_q[up_idx]   <= 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up_write_data) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed test-plan checks plus randomized traffic
// compared every cycle against an array-based model of the predictor table.
module tb_branch_predictor;

  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int CWS = 4;
  localparam int N   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] lookup_pc;
  logic          take_branch, take_s;
  logic [AW-1:0] branch_predict, bp_s;
  logic          update_valid;
  logic [AW-1:0] update_pc;
  logic          update_taken;
  logic [AW-1:0] update_target;
  logic          update_pred_taken;
  logic [AW-1:0] update_pred_target;
  logic          invalidate;
  logic [CW-1:0]  branch_count, mispredict_count;
  logic [CWS-1:0] bc_s, mc_s;

  branch_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .take_branch(take_branch), .branch_predict(branch_predict),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .invalidate(invalidate),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  // Narrow-counter instance so saturation is reached in a short run.
  branch_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(4), .COUNT_WIDTH(CWS)) dut_small (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .take_branch(take_s), .branch_predict(bp_s),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .invalidate(invalidate),
    .branch_count(bc_s), .mispredict_count(mc_s)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  // Reference model: one record per table slot, plain integers.
  bit     m_valid [N];
  int     m_tag   [N];
  int     m_target[N];
  int     m_ctr   [N];
  longint m_bc = 0, m_mc = 0;

  initial for (int i = 0; i < N; i++) begin
    m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
  end

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_lookup(input logic [AW-1:0] pc, output longint tk, output longint tg);
    int i = (int'(pc) / 2) % N;
    int t = int'(pc) / (2 * N);
    bit hit = m_valid[i] && (m_tag[i] == t);
    tk = (hit && m_ctr[i] >= 2) ? 1 : 0;
    tg = hit ? longint'(m_target[i]) : 0;
  endtask

  always @(posedge clk) begin
    int i, t;
    bit hit, mis;
    if (reset) begin
      for (int k = 0; k < N; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
      m_bc = 0; m_mc = 0;
    end else begin
      if (update_valid) begin
        mis = (update_pred_taken != update_taken) ||
              (update_taken && update_pred_taken && update_pred_target != update_target);
        m_bc++;
        if (mis) m_mc++;
      end
      if (invalidate) begin
        for (int k = 0; k < N; k++) m_valid[k] = 0;
      end else if (update_valid) begin
        i = (int'(update_pc) / 2) % N;
        t = int'(update_pc) / (2 * N);
        hit = m_valid[i] && (m_tag[i] == t);
        if (hit && update_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = int'(update_target);
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end else if (update_taken) begin
          m_valid[i] = 1; m_tag[i] = t; m_target[i] = int'(update_target); m_ctr[i] = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    longint etk, etg;
    if (checking) begin
      model_lookup(lookup_pc, etk, etg);
      chk("model take_branch", longint'(take_branch), etk);
      chk("model branch_predict", longint'(branch_predict), etg);
      chk("model branch_count", longint'(branch_count), sat(m_bc, CW));
      chk("model mispredict_count", longint'(mispredict_count), sat(m_mc, CW));
      chk("model small take_branch", longint'(take_s), etk);
      chk("model small branch_predict", longint'(bp_s), etg);
      chk("model small branch_count", longint'(bc_s), sat(m_bc, CWS));
      chk("model small mispredict_count", longint'(mc_s), sat(m_mc, CWS));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    invalidate   = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic set_upd(input logic [AW-1:0] pc, input bit tk, input logic [AW-1:0] tg,
                         input bit ptk, input logic [AW-1:0] ptg);
    update_valid = 1'b1; update_pc = pc; update_taken = tk; update_target = tg;
    update_pred_taken = ptk; update_pred_target = ptg;
  endtask

  function automatic logic [AW-1:0] pick();
    int t = $urandom_range(0, 2);
    int i = $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) return 16'($urandom()) & 16'hFFFE;
    return 16'((t << 5) | (i << 1));
  endfunction

  initial begin
    reset = 1'b1; invalidate = 1'b0; update_valid = 1'b0;
    lookup_pc = 16'h0040; update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_pred_taken = 1'b0; update_pred_target = '0;
    @(posedge clk); #1;
    tick();
    checking = 1;

    @(negedge clk);
    chk("reset take_branch", longint'(take_branch), 0);
    chk("reset branch_predict", longint'(branch_predict), 0);
    chk("reset branch_count", longint'(branch_count), 0);
    chk("reset mispredict_count", longint'(mispredict_count), 0);

    set_upd(16'h0040, 1, 16'h0100, 0, 16'h0000); tick();
    @(negedge clk);
    chk("alloc take_branch", longint'(take_branch), 1);
    chk("alloc branch_predict", longint'(branch_predict), 16'h0100);
    chk("alloc branch_count", longint'(branch_count), 1);
    chk("alloc mispredict_count", longint'(mispredict_count), 1);

    set_upd(16'h0040, 0, 16'h0000, 1, 16'h0100); tick();
    @(negedge clk);
    chk("ctr1 take_branch", longint'(take_branch), 0);
    chk("ctr1 branch_predict", longint'(branch_predict), 16'h0100);
    set_upd(16'h0040, 0, 16'h0000, 0, 16'h0000); tick();
    @(negedge clk);
    chk("ctr0 take_branch", longint'(take_branch), 0);
    set_upd(16'h0040, 1, 16'h0100, 0, 16'h0000); tick();
    @(negedge clk);
    chk("ctr0to1 take_branch", longint'(take_branch), 0);
    set_upd(16'h0040, 1, 16'h0100, 1, 16'h0100); tick();
    @(negedge clk);
    chk("ctr1to2 take_branch", longint'(take_branch), 1);

    tick(); lookup_pc = 16'h0060;
    @(negedge clk);
    chk("alias miss take_branch", longint'(take_branch), 0);
    chk("alias miss branch_predict", longint'(branch_predict), 0);
    set_upd(16'h0060, 1, 16'h0200, 0, 16'h0000); tick(); lookup_pc = 16'h0040;
    @(negedge clk);
    chk("evicted take_branch", longint'(take_branch), 0);
    chk("evicted branch_predict", longint'(branch_predict), 0);
    tick(); lookup_pc = 16'h0060;
    @(negedge clk);
    chk("alias hit take_branch", longint'(take_branch), 1);
    chk("alias hit branch_predict", longint'(branch_predict), 16'h0200);

    tick(); set_upd(16'h0060, 1, 16'h0300, 1, 16'h0200);
    @(negedge clk);
    chk("same-cycle old target", longint'(branch_predict), 16'h0200);
    tick();
    @(negedge clk);
    chk("next-cycle new target", longint'(branch_predict), 16'h0300);

    tick(); invalidate = 1'b1; set_upd(16'h0080, 1, 16'h0400, 1, 16'h0400);
    tick();
    @(negedge clk);
    chk("inval take_branch", longint'(take_branch), 0);
    chk("inval branch_predict", longint'(branch_predict), 0);
    chk("inval branch_count", longint'(branch_count), 8);
    chk("inval mispredict_count", longint'(mispredict_count), 5);
    chk("inval small branch_count", longint'(bc_s), 8);
    tick(); lookup_pc = 16'h0080;
    @(negedge clk);
    chk("inval suppressed alloc", longint'(take_branch), 0);

    tick(); lookup_pc = 16'h0040; set_upd(16'h0040, 1, 16'h0500, 0, 16'h0000);
    tick();
    @(negedge clk);
    chk("realloc branch_predict", longint'(branch_predict), 16'h0500);
    tick(); reset = 1'b1; set_upd(16'h0040, 1, 16'h0600, 0, 16'h0000);
    tick();
    @(negedge clk);
    chk("reset-upd take_branch", longint'(take_branch), 0);
    chk("reset-upd branch_predict", longint'(branch_predict), 0);
    chk("reset-upd branch_count", longint'(branch_count), 0);
    chk("reset-upd mispredict_count", longint'(mispredict_count), 0);

    for (int n = 0; n < 3000; n++) begin
      tick();
      reset        = ($urandom_range(0, 199) == 0);
      invalidate   = ($urandom_range(0, 63) == 0);
      update_valid = $urandom_range(0, 1) != 0;
      update_pc    = pick();
      update_taken = $urandom_range(0, 1) != 0;
      update_target = 16'($urandom()) & 16'hFFFE;
      update_pred_taken = $urandom_range(0, 1) != 0;
      update_pred_target = ($urandom_range(0, 1) != 0) ? update_target
                                                        : 16'($urandom()) & 16'hFFFE;
      lookup_pc = ($urandom_range(0, 3) == 0) ? update_pc : pick();
    end
    tick();
    @(negedge clk);
    checking = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
